// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// Serialises accesses through an IDLE -> ACCESS -> RESP handshake, one transaction per 3 cycles.
module dm_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          dm_MemR,
  output logic          dm_MemWr,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_data,
  input  logic [DW-1:0] dm_ReadData,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    ack_q, ack_d;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    sel_we    = gnt_q ? m1_we    : m0_we;
    sel_addr  = gnt_q ? m1_addr  : m0_addr;
    sel_wdata = gnt_q ? m1_wdata : m0_wdata;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          // On a tie the port not served last wins.
          gnt_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          state_d = StAccess;
        end
      end
      StAccess: begin
        last_d  = gnt_q;
        ack_d   = gnt_q ? 2'b10 : 2'b01;
        if (!sel_we) rdata_d = dm_ReadData;
        state_d = StResp;
      end
      StResp: begin
        ack_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        ack_d   = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // DM strobes are decoded from state so reset kills a pending write before the edge.
  always_comb begin
    dm_MemR  = 1'b0;
    dm_MemWr = 1'b0;
    dm_addr  = '0;
    dm_data  = '0;
    if (state_q == StAccess) begin
      dm_MemR  = ~sel_we;
      dm_MemWr = sel_we;
      dm_addr  = sel_addr;
      dm_data  = sel_wdata;
    end
  end

  always_comb begin
    m0_ack   = ack_q[0];
    m1_ack   = ack_q[1];
    m0_rdata = rdata_q;
    m1_rdata = rdata_q;
    busy     = (state_q != StIdle);
    grant_id = gnt_q;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port round-robin arbiter that shares the single-ported data memory (DM: 512 x 32-bit words, synchronous write, combinational read gated by MemR) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It sits directly in front of DM and serialises accesses through a three-state FSM with a req/ack handshake. Read data returns registered, and writes commit on the DM clock edge that ends the access cycle.

## Interface
- AW, 32, address width passed through to DM (byte address; DM indexes by addr>>2)
- DW, 32, data width
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 request; held high with m0_we/m0_addr/m0_wdata stable until m0_ack
- m0_we  in  1  port 0: 1 = write, 0 = read
- m0_addr  in  AW  port 0 byte address
- m0_wdata  in  DW  port 0 write data
- m0_ack  out  1  port 0 one-cycle completion pulse
- m0_rdata  out  DW  port 0 read data, valid while m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
- dm_MemR  out  1  DM read enable
- dm_MemWr  out  1  DM write enable
- dm_addr  out  AW  DM address
- dm_data  out  DW  DM write data
- dm_ReadData  in  DW  DM combinational read data
- busy  out  1  high in ACCESS and RESP
- grant_id  out  1  port owning the current or last transaction

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, gnt (1 bit), last (1 bit, last port served), rdata_q (DW), ack_q (2 bits).
- IDLE: if neither req, stay. If exactly one req, gnt <= that port. If both, gnt <= ~last (round-robin). On any grant, go to ACCESS.
- ACCESS (exactly 1 cycle): DM signals are driven combinationally from the granted port. dm_addr = mX_addr, dm_data = mX_wdata, dm_MemWr = mX_we, dm_MemR = ~mX_we. At the end of the cycle, DM commits any write, rdata_q <= dm_ReadData for reads (unchanged for writes), last <= gnt, ack_q[gnt] <= 1. Then go to RESP.
- RESP (exactly 1 cycle): mX_ack=1 for the granted port only. mX_rdata = rdata_q. Next state is always IDLE; ack_q cleared.
- m0_rdata/m1_rdata both present rdata_q; valid only when qualified by their own ack.
- Outside ACCESS, dm_MemR = dm_MemWr = 0, dm_addr = 0, dm_data = 0. No spurious DM write is possible in IDLE/RESP.
- Requester rule: drop req (or present a new request) in the cycle after ack. req high in IDLE is always a new transaction.
- req deasserted by a requester during ACCESS is a protocol violation. The transaction completes regardless.
- busy = (state != IDLE). grant_id = gnt.

## Timing
- Reset values: state=IDLE, gnt=0, last=1 (port 0 wins the first tie), rdata_q=0, all ack=0, all dm_* outputs 0, busy=0.
- Latency: req sampled high at edge N (in IDLE) -> ACCESS in cycle N+1 -> ack in cycle N+2. A write is visible in DM after edge N+2.
- Throughput: one transaction per 3 cycles. With both ports saturating, grants alternate 0,1,0,1.
- Simultaneous req: winner is ~last. The loser waits at most one transaction (3 cycles) plus its own 3.
- A new req arriving during ACCESS/RESP is not sampled until IDLE.
- Reset mid-ACCESS: dm_MemWr falls asynchronously with state, so the write must not commit. The ack is never issued. The requester must reissue.
- Reset mid-RESP: ack drops immediately. The DM write has already committed.
- Address wrap: arbiter passes addr unmodified. Out-of-range and alignment behaviour is DM's.

## Test plan
- Port 0 write 0x1234_5678 to addr 0x10, then port 0 read addr 0x10 -> m0_ack two cycles after each req sample; m0_rdata = 0x1234_5678; dm_MemWr high exactly one cycle.
- m0 and m1 both raise req in the same cycle after reset (m0 writes 0xA to 0x0, m1 reads 0x0) -> m0 served first, m1_ack 3 cycles later with m1_rdata = 0xA.
- Both ports hold back-to-back requests for 8 transactions -> grant_id sequence 0,1,0,1,...; no port gets two consecutive grants while the other waits.
- Only m1 requests repeatedly -> served every 3 cycles; m0_ack stays 0.
- Assert rst during ACCESS of a write of 0xDEAD to 0x20 -> no ack; later read of 0x20 returns 0; all outputs return to reset values immediately.
- Read of a never-written address 0x40 -> m0_rdata = 0. In IDLE, dm_MemR = dm_MemWr = 0 throughout.
